// File: rtl/simd_pkg.sv
// Shared types and sizing defaults for the SIMD loop-nest sequencer.
package simd_pkg;

    localparam int LOOP_ID_W_DEF  = 5;
    localparam int GROUP_ID_W_DEF = 2;
    localparam int ITER_W_DEF     = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_ALIGN,
        ST_RUN,
        ST_FINISH
    } state_e;

endpackage

// File: rtl/simd_loop_counter.sv
// One loop level: counts 0..max_val, wrapping to 0 when advanced at max.
module simd_loop_counter
    import simd_pkg::*;
#(
    parameter int ITER_W = ITER_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              adv,
    input  logic [ITER_W-1:0] max_val,
    output logic              at_max
);

    logic [ITER_W-1:0] cnt_q, cnt_d;

    assign at_max = (cnt_q == max_val);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (adv) begin
            cnt_d = at_max ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/simd_loop_iter_ctrl.sv
// Loop-nest sequencer: stores per-group iteration counts and steps an
// odometer of loop counters, driving the address walkers' start/step/stall.
module simd_loop_iter_ctrl
    import simd_pkg::*;
#(
    parameter  int LOOP_ID_W      = LOOP_ID_W_DEF,
    parameter  int GROUP_ID_W     = GROUP_ID_W_DEF,
    parameter  int GROUP_ENABLED  = 1,
    parameter  int ITER_W         = ITER_W_DEF,
    localparam int NUM_MAX_LOOPS  = 1 << LOOP_ID_W,
    localparam int NUM_MAX_GROUPS = 1 << GROUP_ID_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_loop_iter_v,
    input  logic [ITER_W-1:0]        cfg_loop_iter,
    input  logic [GROUP_ID_W-1:0]    cfg_loop_group_id,
    input  logic                     block_done,
    input  logic                     start,
    input  logic [GROUP_ID_W-1:0]    loop_group_id,
    input  logic                     stall_in,
    output logic                     walker_start,
    output logic [NUM_MAX_LOOPS:0]   iter_done,
    output logic                     walker_stall,
    output logic                     busy,
    output logic                     done
);

    state_e                  state_q, state_d;
    logic [GROUP_ID_W-1:0]   grp_q, grp_d;
    logic [LOOP_ID_W-1:0]    wptr_q [NUM_MAX_GROUPS];
    logic [LOOP_ID_W-1:0]    wptr_d [NUM_MAX_GROUPS];
    logic [ITER_W-1:0]       iter_q [NUM_MAX_GROUPS][NUM_MAX_LOOPS];
    logic [ITER_W-1:0]       iter_d [NUM_MAX_GROUPS][NUM_MAX_LOOPS];

    logic [GROUP_ID_W-1:0]   cfg_gid, run_gid;
    logic                    step, cnt_clr;
    logic [NUM_MAX_LOOPS-1:0] at_max;
    logic [NUM_MAX_LOOPS:0]  inner_max;

    // With groups disabled every id collapses to bank 0; the other banks are
    // never written and stay constant zero.
    assign cfg_gid = (GROUP_ENABLED != 0) ? cfg_loop_group_id : '0;
    assign run_gid = (GROUP_ENABLED != 0) ? loop_group_id : '0;

    assign step    = (state_q == ST_RUN) && !stall_in;
    assign cnt_clr = (state_q == ST_IDLE) && start;

    // inner_max[i]: every loop from i inward sits at its maximum.
    always_comb begin
        inner_max[NUM_MAX_LOOPS] = 1'b1;
        for (int i = NUM_MAX_LOOPS - 1; i >= 0; i--) begin
            inner_max[i] = inner_max[i+1] & at_max[i];
        end
    end

    for (genvar i = 0; i < NUM_MAX_LOOPS; i++) begin : g_loop
        simd_loop_counter #(.ITER_W(ITER_W)) u_cnt (
            .clk    (clk),
            .reset  (reset),
            .clr    (cnt_clr),
            .adv    (step && inner_max[i+1]),
            .max_val(iter_q[grp_q][i]),
            .at_max (at_max[i])
        );
    end

    always_comb begin
        iter_d = iter_q;
        wptr_d = wptr_q;
        if ((state_q == ST_IDLE) && cfg_loop_iter_v) begin
            iter_d[cfg_gid][wptr_q[cfg_gid]] = cfg_loop_iter;
            wptr_d[cfg_gid] = wptr_q[cfg_gid] + 1'b1;
        end
        if (block_done) begin
            for (int g = 0; g < NUM_MAX_GROUPS; g++) begin
                wptr_d[g] = '0;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grp_d        = grp_q;
        walker_start = 1'b0;
        walker_stall = 1'b1;
        busy         = 1'b1;
        done         = 1'b0;
        iter_done    = '0;
        unique case (state_q)
            ST_IDLE: begin
                walker_stall = 1'b0;
                busy         = 1'b0;
                if (start) begin
                    grp_d   = run_gid;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                walker_start = 1'b1;
                state_d      = ST_ALIGN;
            end
            ST_ALIGN: state_d = ST_RUN;
            ST_RUN: begin
                walker_stall = stall_in;
                if (step) begin
                    iter_done = inner_max;
                    if (inner_max[0]) state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grp_q   <= '0;
            wptr_q  <= '{default: '0};
            iter_q  <= '{default: '{default: '0}};
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            wptr_q  <= wptr_d;
            iter_q  <= iter_d;
        end
    end

endmodule

// File: tb/tb_simd_loop_iter_ctrl.sv
// Bench for simd_loop_iter_ctrl: mixed-radix reference model checked every
// cycle, plus directed nests with hand-computed timing and step counts.
module tb_simd_loop_iter_ctrl;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_loop_iter_v = 1'b0;
    logic [15:0] cfg_loop_iter = '0;
    logic [1:0]  cfg_loop_group_id = '0;
    logic        block_done = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  loop_group_id = '0;
    logic        stall_in = 1'b0;
    logic        walker_start, walker_stall, busy, done;
    logic [N:0]  iter_done;

    int checks = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    simd_loop_iter_ctrl dut (
        .clk(clk), .reset(reset),
        .cfg_loop_iter_v(cfg_loop_iter_v), .cfg_loop_iter(cfg_loop_iter),
        .cfg_loop_group_id(cfg_loop_group_id), .block_done(block_done),
        .start(start), .loop_group_id(loop_group_id), .stall_in(stall_in),
        .walker_start(walker_start), .iter_done(iter_done),
        .walker_stall(walker_stall), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 launch, 2 align, 3 run, 4 finish;
    // m_k is the number of steps already issued in the current nest.
    int unsigned     m_iter [4][N];
    int              m_wptr [4];
    int              m_ph = 0;
    int              m_grp = 0;
    longint unsigned m_k = 0;

    // Decompose the step index into mixed-radix digits, innermost fastest.
    function automatic logic [N:0] model_iter_done(input logic stl);
        logic [N:0]      r;
        longint unsigned rem, rad;
        logic            all_max;
        r = '0;
        if (m_ph != 3 || stl) return r;
        rem = m_k;
        all_max = 1'b1;
        r[N] = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            rad = longint'(m_iter[m_grp][i]) + 1;
            all_max = all_max && ((rem % rad) == m_iter[m_grp][i]);
            rem = rem / rad;
            r[i] = all_max;
        end
        return r;
    endfunction

    always @(posedge clk) begin : model_upd
        logic [N:0] e;
        e = model_iter_done(stall_in);
        if (reset) begin
            for (int g = 0; g < 4; g++) begin
                m_wptr[g] = 0;
                for (int i = 0; i < N; i++) m_iter[g][i] = 0;
            end
            m_ph = 0; m_grp = 0; m_k = 0;
        end else begin
            if (m_ph == 0 && cfg_loop_iter_v) begin
                m_iter[cfg_loop_group_id][m_wptr[cfg_loop_group_id]] = cfg_loop_iter;
                m_wptr[cfg_loop_group_id] = (m_wptr[cfg_loop_group_id] + 1) % N;
            end
            if (block_done) for (int g = 0; g < 4; g++) m_wptr[g] = 0;
            case (m_ph)
                0: if (start) begin m_ph = 1; m_grp = loop_group_id; m_k = 0; end
                1: m_ph = 2;
                2: m_ph = 3;
                3: if (e[N]) begin
                       if (e[0]) m_ph = 4;
                       else m_k++;
                   end
                default: m_ph = 0;
            endcase
        end
    end

    always @(negedge clk) begin : compare
        if (chk_en) begin
            chk("walker_start", walker_start, m_ph == 1);
            chk("iter_done", iter_done, model_iter_done(stall_in));
            chk("walker_stall", walker_stall,
                (m_ph == 0) ? 1'b0 : (m_ph == 3) ? stall_in : 1'b1);
            chk("busy", busy, m_ph != 0);
            chk("done", done, m_ph == 4);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic cfg_write(input int g, input int v);
        cfg_loop_group_id = g[1:0];
        cfg_loop_iter = v[15:0];
        cfg_loop_iter_v = 1'b1;
        tick();
        cfg_loop_iter_v = 1'b0;
    endtask

    task automatic pulse_bd();
        block_done = 1'b1; tick(); block_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0;
    endtask

    task automatic start_grp(input int g);
        loop_group_id = g[1:0]; start = 1'b1; tick(); start = 1'b0;
    endtask

    // Watches one nest; cycle 1 is the cycle after start was sampled.
    task automatic observe(input int stall_after, input int stall_len, input int poke_cyc,
                           input int abort_after, output int n_ws, output int ws_cyc,
                           output int first_step, output int n_step, output int n_inner,
                           output int n_id1, output int n_id0, output int done_cyc,
                           output logic last_ones);
        int c = 1;
        int rem = stall_len;
        n_ws = 0; ws_cyc = -1; first_step = -1; n_step = 0; n_inner = 0;
        n_id1 = 0; n_id0 = 0; done_cyc = -1; last_ones = 1'b0;
        while (c <= 200) begin
            @(negedge clk);
            if (walker_start) begin n_ws++; if (ws_cyc < 0) ws_cyc = c; end
            if (iter_done[N]) begin
                n_step++;
                if (first_step < 0) first_step = c;
                if (iter_done[N-1]) n_inner++;
                if (iter_done[1]) n_id1++;
                if (iter_done[0]) n_id0++;
                last_ones = &iter_done;
            end
            if (done) begin done_cyc = c; break; end
            tick();
            stall_in = 1'b0; start = 1'b0; cfg_loop_iter_v = 1'b0;
            if (n_step == stall_after && rem > 0) begin stall_in = 1'b1; rem--; end
            if (c + 1 == poke_cyc) begin
                start = 1'b1; loop_group_id = 2'd1;
                cfg_loop_iter_v = 1'b1; cfg_loop_iter = 16'd5; cfg_loop_group_id = 2'd0;
            end
            if (abort_after > 0 && n_step == abort_after) begin reset = 1'b1; break; end
            c++;
        end
        if (abort_after == 0) begin
            chk("nest_completes", done_cyc > 0, 1'b1);
            tick();
        end
        start = 1'b0; cfg_loop_iter_v = 1'b0; stall_in = 1'b0;
    endtask

    initial begin
        int nws, wsc, fst, nst, ninr, n1, n0, dc;
        logic lo;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;

        // 2x3 nest on group 0
        cfg_write(0, 1); cfg_write(0, 2);
        chk("model_slot0", m_iter[0][0], 1);
        chk("model_slot1", m_iter[0][1], 2);
        chk("model_wptr", m_wptr[0], 2);
        start_grp(0);
        observe(-1, 0, 0, 0, nws, wsc, fst, nst, ninr, n1, n0, dc, lo);
        chk("t1_ws_cycle", wsc, 1);
        chk("t1_first_step", fst, 3);
        chk("t1_steps", nst, 6);
        chk("t1_inner_wraps", ninr, 6);
        chk("t1_loop1_wraps", n1, 2);
        chk("t1_loop0_wraps", n0, 1);
        chk("t1_done_cycle", dc, 9);

        // same nest, two stalled cycles where step 2 would be
        start_grp(0);
        observe(1, 2, 0, 0, nws, wsc, fst, nst, ninr, n1, n0, dc, lo);
        chk("t2_steps", nst, 6);
        chk("t2_done_cycle", dc, 11);

        // groups are independent
        do_reset();
        cfg_write(0, 3);
        cfg_write(1, 1); cfg_write(1, 1);
        start_grp(1);
        observe(-1, 0, 0, 0, nws, wsc, fst, nst, ninr, n1, n0, dc, lo);
        chk("t3_g1_steps", nst, 4);
        chk("t3_g1_loop0", n0, 1);
        chk("t3_g1_done", dc, 7);
        start_grp(0);
        observe(-1, 0, 0, 0, nws, wsc, fst, nst, ninr, n1, n0, dc, lo);
        chk("t3_g0_steps", nst, 4);

        // unconfigured group: one all-ones step
        start_grp(2);
        observe(-1, 0, 0, 0, nws, wsc, fst, nst, ninr, n1, n0, dc, lo);
        chk("t4_steps", nst, 1);
        chk("t4_all_ones", lo, 1'b1);
        chk("t4_done_cycle", dc, 4);

        // start and config writes while busy are ignored
        do_reset();
        cfg_write(0, 1); cfg_write(0, 2);
        start_grp(0);
        observe(-1, 0, 2, 0, nws, wsc, fst, nst, ninr, n1, n0, dc, lo);
        chk("t5_ws_count", nws, 1);
        chk("t5_steps", nst, 6);
        start_grp(0);
        observe(-1, 0, 0, 0, nws, wsc, fst, nst, ninr, n1, n0, dc, lo);
        chk("t5_rerun_steps", nst, 6);

        // reset mid-run
        start_grp(0);
        observe(-1, 0, 0, 3, nws, wsc, fst, nst, ninr, n1, n0, dc, lo);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_busy_after_reset", busy, 1'b0);
        chk("t6_iter_done_after_reset", iter_done, '0);
        tick();
        start_grp(0);
        observe(-1, 0, 0, 0, nws, wsc, fst, nst, ninr, n1, n0, dc, lo);
        chk("t6_cleared_steps", nst, 1);
        cfg_write(3, 1); cfg_write(3, 1);
        pulse_bd();
        cfg_write(3, 2);
        start_grp(3);
        observe(-1, 0, 0, 0, nws, wsc, fst, nst, ninr, n1, n0, dc, lo);
        chk("t6_bd_slot0_steps", nst, 6);

        // randomized nests with stalls, noise and occasional resets
        for (int t = 0; t < 40; t++) begin
            int tg, nw, guard;
            if ($urandom % 8 == 0) do_reset();
            if ($urandom % 4 == 0) begin
                cfg_loop_group_id = 2'($urandom % 4);
                cfg_loop_iter = 16'($urandom % 3);
                cfg_loop_iter_v = 1'b1;
            end
            pulse_bd();
            cfg_loop_iter_v = 1'b0;
            tg = int'($urandom % 4);
            nw = int'($urandom % 4);
            for (int w = 0; w < nw; w++)
                cfg_write(($urandom % 4 == 0) ? int'($urandom % 4) : tg, int'($urandom % 3));
            start_grp(tg);
            guard = 0;
            while (guard < 2000 && (busy || guard < 2)) begin
                stall_in = ($urandom % 3 == 0);
                reset = ($urandom % 200 == 0);
                if (busy && $urandom % 8 == 0) begin
                    start = 1'b1; loop_group_id = 2'($urandom % 4);
                    cfg_loop_iter_v = 1'b1; cfg_loop_iter = 16'($urandom % 3);
                    cfg_loop_group_id = 2'($urandom % 4);
                end
                tick();
                start = 1'b0; cfg_loop_iter_v = 1'b0; reset = 1'b0;
                guard++;
            end
            stall_in = 1'b0;
            chk("rand_nest_bounded", guard < 2000, 1'b1);
            tick();
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
